// File: rtl/mcpu_fetch_queue_if.sv
// mcpu_fetch_queue_if: instruction-port, decode handshake and redirect bundle for the fetch queue
interface mcpu_fetch_queue_if #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
);
  logic                    imem_req;
  logic [ADDR_WIDTH-1:0]   imem_addr;
  logic [WORD_SIZE-1:0]    imem_rdata;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [WORD_SIZE-1:0]    instr_word;
  logic [ADDR_WIDTH-1:0]   instr_pc;
  logic                    redirect;
  logic [ADDR_WIDTH-1:0]   redirect_pc;
  logic [$clog2(DEPTH):0]  occupancy;
  modport master (
    output imem_req, imem_addr, instr_valid, instr_word, instr_pc, occupancy,
    input  imem_rdata, instr_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_word, instr_pc, occupancy,
    output imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/mcpu_fetch_queue.sv
// mcpu_fetch_queue: sequential prefetch into a small FIFO with redirect flush; define MCPU_FETCH_BYPASS_EN for same-cycle bypass of an empty FIFO
module mcpu_fetch_queue #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input logic clk,
  input logic reset,
  mcpu_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] fpc, infl_pc;
  logic                  infl, kill;
  logic [WORD_SIZE-1:0]  mem_w  [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc [DEPTH];
  logic [PW-1:0]         rptr, wptr;
  logic [CW-1:0]         count;
  logic                  has, arrive, byp, pop, fpop, push;
  assign has    = count != '0;
  assign arrive = infl && !kill;
`ifdef MCPU_FETCH_BYPASS_EN
  assign byp = arrive && !has;
`else
  assign byp = 1'b0;
`endif
  // registered count only: a same-cycle pop never frees a slot for issue
  assign bus.imem_req    = !reset && !bus.redirect && (int'(count) + int'(infl) < DEPTH);
  assign bus.imem_addr   = fpc;
  assign bus.instr_valid = has || byp;
  assign bus.instr_word  = has ? mem_w[rptr]  : byp ? bus.imem_rdata : '0;
  assign bus.instr_pc    = has ? mem_pc[rptr] : byp ? infl_pc        : '0;
  assign bus.occupancy   = count;
  assign pop  = bus.instr_valid && bus.instr_ready && !bus.redirect;
  assign fpop = pop && has;
  // a bypassed word consumed in its arrival cycle never enters storage
  assign push = arrive && !bus.redirect && !(byp && pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc     <= '0;
      infl    <= 1'b0;
      infl_pc <= '0;
      kill    <= 1'b0;
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
    end else begin
      infl <= bus.imem_req;
      kill <= bus.redirect && infl;
      if (bus.imem_req) begin
        fpc     <= fpc + 1'b1;
        infl_pc <= fpc;
      end
      if (bus.redirect) begin
        fpc   <= bus.redirect_pc;
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        rptr  <= rptr + PW'(fpop);
        wptr  <= wptr + PW'(push);
        count <= count + CW'(push) - CW'(fpop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_w[wptr]  <= bus.imem_rdata;
      mem_pc[wptr] <= infl_pc;
    end
  end
endmodule
